aes_iter_core: RTL

- Iterative AES-128 encryption engine; the sequential successor to the single-cycle round block.
- Holds state and round key in registers and reuses the existing substitute/shiftrows/mixColumns/keyexpand logic for ROUNDS_PER_CYCLE rounds per clock.
- Valid/ready handshakes on both sides; sits between the host data interface and the ciphertext sink.

---
 rtl/aes_iter_core.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock.
// Optional abort port is compiled in when AES_ITER_ABORT_EN is defined.
module aes_iter_core #(
    parameter int NUM_ROUNDS       = 10,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy,
`ifdef AES_ITER_ABORT_EN
    input  logic         abort,
`endif
    output logic [3:0]   round_idx
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10 ||
        (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) ||
        (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_cfg_err
        $error("aes_iter_core: illegal NUM_ROUNDS/ROUNDS_PER_CYCLE");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t         fsm;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] s_nxt;
    logic [127:0] k_nxt;
    logic [3:0]   rnd;
    logic [3:0]   idx_nxt;
    logic         accept;
    logic         abort_req;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] key_step(
        input logic [127:0] k,
        input logic [7:0]   rc
    );
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        // RotWord then SubWord, Rcon folded into the top byte
        t  = {sbox(w3[23:16]), sbox(w3[15:8]),
              sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] enc_round(
        input logic [127:0] s,
        input logic [127:0] rk,
        input logic         last
    );
        logic [127:0] t, m;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] =
                    sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        m = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127-32*c -: 8];
                a1 = t[119-32*c -: 8];
                a2 = t[111-32*c -: 8];
                a3 = t[103-32*c -: 8];
                m[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                m[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                m[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                m[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return m ^ rk;
    endfunction

    always_comb begin
        s_nxt = state_reg;
        k_nxt = key_reg;
        rnd   = round_idx;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            rnd   = round_idx + 4'(i + 1);
            k_nxt = key_step(k_nxt, rcon(rnd));
            s_nxt = enc_round(s_nxt, k_nxt, rnd == 4'(NUM_ROUNDS));
        end
    end

    assign idx_nxt = round_idx + 4'(ROUNDS_PER_CYCLE);

`ifdef AES_ITER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_ready = (fsm == IDLE) && !rst && !abort_req;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            dout      <= '0;
            round_idx <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort_req && fsm != IDLE) begin
            fsm       <= IDLE;
            dout      <= '0;
            round_idx <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (accept) begin
                        state_reg <= data ^ key;
                        key_reg   <= key;
                        round_idx <= '0;
                        busy      <= 1'b1;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    state_reg <= s_nxt;
                    key_reg   <= k_nxt;
                    round_idx <= idx_nxt;
                    if (idx_nxt == 4'(NUM_ROUNDS)) begin
                        dout      <= s_nxt;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        round_idx <= '0;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
